// File: rtl/float_pkg.sv
// Shared single-precision float helpers for the resampler back end.
// Field layout, IEEE-754 constants and a special-value classifier.
package float_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  localparam int EXP_BIAS  = 127;
  localparam int MANT_BITS = 23;
  localparam int EXP_MAX   = 255;

  // All-ones exponent: infinity (mantissa zero) or NaN (mantissa non-zero).
  function automatic logic is_nan_inf(input float32_t f);
    return (f.exp == 8'(EXP_MAX));
  endfunction

endpackage

// File: rtl/float_to_fixed_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word fall-through FIFO.
// dout shows the head entry while non-empty and holds the last popped
// word while empty. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout  = empty ? hold_q : mem_q[rd_ptr_q];
  assign count = count_q;

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Remember the word leaving the head so dout is stable once empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (do_pop) begin
      hold_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage array; at full with a pop the tail slot is the departing head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/float_to_fixed_fifo.sv
// float_to_fixed_fifo: float32 -> saturated signed fixed point, buffered in a
// FWFT FIFO with a valid/ready reader. The writer has no backpressure, so
// samples that meet a full FIFO are dropped and the sticky overflow is set.
// Optional macro FLOAT_TO_FIXED_ROUND_NEAREST_EN: round half away from zero
// instead of truncating toward zero. BITS must be 32.
module float_to_fixed_fifo
  import float_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int OUT_BITS = 24,
  parameter int FRAC     = 16,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [BITS-1:0]        x,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_BITS-1:0]    y,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  // Magnitude carries OUT_BITS+1 bits plus a guard bit.
  localparam int MAG_W = OUT_BITS + 2;
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(1) << (OUT_BITS - 1);
  localparam logic [MAG_W-1:0] POS_LIM = NEG_LIM - 1'b1;
  localparam logic signed [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  // Half away from zero on the magnitude; cannot overflow MAG_W.
  function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] m,
                                                 input logic r);
    return m + MAG_W'(r);
  endfunction
`endif

  // Apply sign and clamp; exactly -2^(OUT_BITS-1) passes through unsaturated.
  function automatic logic signed [OUT_BITS-1:0] saturate(input logic s,
                                                          input logic big,
                                                          input logic [MAG_W-1:0] m);
    if (!s) begin
      if (big || (m > POS_LIM)) return OUT_MAX;
      return OUT_BITS'(m);
    end
    if (big || (m > NEG_LIM)) return OUT_MIN;
    return OUT_BITS'(-m);
  endfunction

  float32_t           f;
  logic [23:0]        mant24;
  logic [MAG_W-1:0]   mant_ext;
  int                 sh;
  int                 rsh;

  logic               vld_p1_q;
  logic               sign_p1_q;
  logic               big_p1_d, big_p1_q;
  logic [MAG_W-1:0]   mag_p1_d, mag_p1_q;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  logic               rnd_p1_d, rnd_p1_q;
`endif

  logic [MAG_W-1:0]            mag_p2_d;
  logic signed [OUT_BITS-1:0]  data_p2_d, data_p2_q;
  logic                        vld_p2_q;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic drop;
  logic overflow_q;

  assign f        = float32_t'(x[31:0]);
  assign mant24   = {1'b1, f.mant};
  assign mant_ext = MAG_W'(mant24);

  // Stage 1 decode: align {1,m} to the output binary point, flag out-of-range.
  always_comb begin
    sh       = int'(f.exp) - (EXP_BIAS + MANT_BITS) + FRAC;
    rsh      = 0;
    big_p1_d = 1'b0;
    mag_p1_d = '0;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
    rnd_p1_d = 1'b0;
`endif
    if (f.exp == 8'd0) begin
      // zero and denormals convert to 0
      mag_p1_d = '0;
    end else if (is_nan_inf(f)) begin
      // NaN -> 0, infinity -> saturate with sign
      big_p1_d = (f.mant == '0);
    end else if (sh + MANT_BITS >= OUT_BITS - 1) begin
      big_p1_d = 1'b1;
    end else if (sh >= 0) begin
      mag_p1_d = mant_ext << sh;
    end else begin
      rsh = -sh;
      if (rsh <= MANT_BITS + 1) begin
        mag_p1_d = mant_ext >> rsh;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
        rnd_p1_d = mant24[5'(rsh - 1)];
`endif
      end
    end
  end

  // ---- stage 1 register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= in_valid;
  end

  // Stage 1 datapath register (not reset; qualified by vld_p1_q).
  always_ff @(posedge clk) begin
    sign_p1_q <= f.sign;
    big_p1_q  <= big_p1_d;
    mag_p1_q  <= mag_p1_d;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
    rnd_p1_q  <= rnd_p1_d;
`endif
  end

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
  assign mag_p2_d = round_mag(mag_p1_q, rnd_p1_q);
`else
  assign mag_p2_d = mag_p1_q;
`endif
  assign data_p2_d = saturate(sign_p1_q, big_p1_q, mag_p2_d);

  // ---- stage 2 register boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p2_q <= 1'b0;
    else       vld_p2_q <= vld_p1_q;
  end

  // Stage 2 datapath register.
  always_ff @(posedge clk) begin
    data_p2_q <= data_p2_d;
  end

  // Drop decision: a full FIFO still accepts if the reader pops this cycle.
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = vld_p2_q && (!fifo_full || fifo_pop);
  assign drop      = vld_p2_q && fifo_full && !fifo_pop;

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (data_p2_q),
    .pop   (fifo_pop),
    .dout  (y),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
